// File: rtl/req_encoder_8to3.sv
// req_encoder_8to3: accumulates 8 request lines and offers one pending index as a 3-bit code over valid/ready.
// Define ROUND_ROBIN_EN for rotating priority; otherwise highest index wins.
module req_encoder_8to3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       ready,
    output logic       valid,
    output logic [2:0] code,
    output logic [7:0] pending,
    output logic       lost
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t     r_state;
    logic       r_valid;
    logic [2:0] r_code;
    logic [7:0] r_pending;
    logic       r_lost;
    logic       w_acc;
    logic [7:0] w_clr;
    logic [7:0] w_req;
    logic [7:0] w_pend_next;
    logic [2:0] w_start;

    // Downward search from s, wrapping; the first set bit found wins.
    function automatic logic [2:0] f_sel(input logic [7:0] v, input logic [2:0] s);
        logic [2:0] r;
        logic [2:0] k;
        logic       f;
        r = 3'd0;
        f = 1'b0;
        for (int i = 0; i < 8; i++) begin
            k = s - 3'(i);
            if (!f && v[k]) begin
                r = k;
                f = 1'b1;
            end
        end
        return r;
    endfunction

    assign w_acc       = r_valid & ready;
    assign w_clr       = w_acc ? (8'd1 << r_code) : 8'd0;
    assign w_req       = en ? req : 8'd0;
    assign w_pend_next = (r_pending & ~w_clr) | w_req;

`ifdef ROUND_ROBIN_EN
    logic [2:0] r_ptr;
    // The code being accepted becomes the new pointer in the same edge it is searched from.
    assign w_start = (w_acc ? r_code : r_ptr) - 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= 3'd0;
        else if (w_acc)
            r_ptr <= r_code;
    end
`else
    assign w_start = 3'd7;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_valid   <= 1'b0;
            r_code    <= 3'd0;
            r_pending <= 8'h00;
            r_lost    <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            r_lost    <= |(w_req & r_pending & ~w_clr);
            case (r_state)
                IDLE: begin
                    if (en && |r_pending) begin
                        r_state <= OFFER;
                        r_valid <= 1'b1;
                        r_code  <= f_sel(r_pending, w_start);
                    end
                end
                OFFER: begin
                    if (ready) begin
                        if (en && |w_pend_next) begin
                            r_code <= f_sel(w_pend_next, w_start);
                        end else begin
                            r_state <= IDLE;
                            r_valid <= 1'b0;
                            r_code  <= 3'd0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_code  <= 3'd0;
                end
            endcase
        end
    end

    assign valid   = r_valid;
    assign code    = r_code;
    assign pending = r_pending;
    assign lost    = r_lost;
endmodule
